// File: rtl/gcd_param_pkg.sv
// Shared types and sizing helpers for the gcd_param block.
// Optional feature macro: GCD_PARAM_ITERS_EN (REDUCE-cycle counter).
package gcd_param_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STRIP  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Upper bound on cycles an operation can take; sizes the iteration counter.
  function automatic int gcd_bound(input int width);
    return 4 * width + 3;
  endfunction

endpackage

// File: rtl/gcd_param_step.sv
// Combinational REDUCE step of the binary GCD: one reduction per call.
module gcd_param_step
  import gcd_param_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] y_next,
  output logic             finish
);

  // First matching rule wins; subtraction always uses the larger operand as minuend.
  always_comb begin
    x_next = x;
    y_next = y;
    finish = 1'b0;
    if (x == '0 || y == '0) begin
      finish = 1'b1;
    end else if (!x[0]) begin
      x_next = x >> 1;
    end else if (!y[0]) begin
      y_next = y >> 1;
    end else if (x > y) begin
      x_next = x - y;
    end else if (x < y) begin
      y_next = y - x;
    end else begin
      y_next = '0;
    end
  end

endmodule

// File: rtl/gcd_param.sv
// Binary (Stein) GCD engine with valid/ready handshake on both sides.
// Optional feature macro: GCD_PARAM_ITERS_EN adds the iters output.
module gcd_param
  import gcd_param_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(gcd_bound(WIDTH))
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GCD_PARAM_ITERS_EN
  output logic [CNT_W-1:0] iters,
`endif
  output logic [WIDTH-1:0] res
);

  localparam int K_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;
  logic             finish;
  logic             strip_shift;
  logic             accept;

  assign accept      = in_valid && (state == IDLE);
  assign strip_shift = (x != '0) && (y != '0) && !x[0] && !y[0];

  gcd_param_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .x      (x),
    .y      (y),
    .x_next (x_next),
    .y_next (y_next),
    .finish (finish)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (in_valid)     state_next = STRIP;
      STRIP:  if (!strip_shift) state_next = REDUCE;
      REDUCE: if (finish)       state_next = DONE;
      DONE:   if (out_ready)    state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand, common-power-of-two and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x   <= '0;
      y   <= '0;
      k   <= '0;
      res <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            x <= a;
            y <= b;
            k <= '0;
          end
        end
        STRIP: begin
          if (strip_shift) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + 1'b1;
          end
        end
        REDUCE: begin
          // k counts only factors of two shared by both operands, so the shift cannot overflow.
          if (finish) res <= ((y == '0) ? x : y) << k;
          else begin
            x <= x_next;
            y <= y_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_PARAM_ITERS_EN
  // Saturating count of REDUCE cycles for the current operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          iters <= '0;
    else if (accept)                       iters <= '0;
    else if (state == REDUCE && iters != '1) iters <= iters + 1'b1;
  end
`endif

endmodule

// File: tb/tb_gcd_param.sv
// Self-checking bench for gcd_param (WIDTH=16 main instance, WIDTH=8 sweep instance).
module tb_gcd_param;
  import gcd_param_pkg::*;

  localparam int W    = 16;
  localparam int W8   = 8;
  localparam int CW   = $clog2(gcd_bound(W));
  localparam int CW8  = $clog2(gcd_bound(W8));
  localparam int BND  = 4 * W + 2;
  localparam int BND8 = 4 * W8 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, res;
  logic [CW-1:0] iters;
  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [W8-1:0] a8, b8, res8;
  logic [CW8-1:0] iters8;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_param #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef GCD_PARAM_ITERS_EN
    .iters(iters),
`endif
    .res(res)
  );

  gcd_param #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
`ifdef GCD_PARAM_ITERS_EN
    .iters(iters8),
`endif
    .res(res8)
  );

`ifndef GCD_PARAM_ITERS_EN
  assign iters  = '0;
  assign iters8 = '0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: Euclid's algorithm on plain integers.
  function automatic int unsigned gcd_ref(input int unsigned p, input int unsigned q);
    int unsigned t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Reference count of REDUCE cycles, from the arithmetic rules of the algorithm.
  function automatic int reduce_cycles(input int unsigned p, input int unsigned q);
    int n = 0;
    while (p != 0 && q != 0 && p % 2 == 0 && q % 2 == 0) begin
      p = p / 2;
      q = q / 2;
    end
    forever begin
      n++;
      if (p == 0 || q == 0) break;
      if (p % 2 == 0)      p = p / 2;
      else if (q % 2 == 0) q = q / 2;
      else if (p > q)      p = p - q;
      else if (p < q)      q = q - p;
      else                 q = 0;
    end
    return n;
  endfunction

  task automatic start16(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait16(output int lat);
    lat = 1;
    while (!out_valid && lat < BND + 10) begin
      @(negedge clk);
      lat++;
    end
    check("timeout16", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic release16();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic op8(input logic [W8-1:0] av, input logic [W8-1:0] bv);
    int lat;
    @(negedge clk);
    in_valid8 = 1'b1;
    a8 = av;
    b8 = bv;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < BND8 + 10) begin
      @(negedge clk);
      lat++;
    end
    check("timeout8", {31'd0, out_valid8}, 32'd1);
    check("res8", res8, gcd_ref(av, bv));
    check("lat8", (lat <= BND8) ? 1 : 0, 1);
`ifdef GCD_PARAM_ITERS_EN
    check("iters8", iters8, reduce_cycles(av, bv));
`endif
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    logic [W-1:0] ra, rb;

    vecs[0] = '{16'd48,     16'd18,     16'd6};
    vecs[1] = '{16'd0,      16'd0,      16'd0};
    vecs[2] = '{16'd0,      16'd35,     16'd35};
    vecs[3] = '{16'd35,     16'd0,      16'd35};
    vecs[4] = '{16'hFFFF,   16'hFFFF,   16'hFFFF};
    vecs[5] = '{16'h8000,   16'h4000,   16'h4000};
    vecs[6] = '{16'd12,     16'd8,      16'd4};
    vecs[7] = '{16'd1,      16'hFFFF,   16'd1};
    vecs[8] = '{16'hFFFE,   16'h8000,   16'd2};
    vecs[9] = '{16'd1024,   16'd768,    16'd256};

    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_iters", iters, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table.
    for (int unsigned i = 0; i < 10; i++) begin
      start16(vecs[i].a, vecs[i].b);
      wait16(lat);
      check("tbl_res", res, vecs[i].exp);
      check("tbl_lat", (lat <= BND) ? 1 : 0, 1);
      if (i == 0) check("k_48_18", dut.k, 32'd1);
      release16();
      check("tbl_idle", {31'd0, in_ready}, 32'd1);
    end

    // Coprime pair with stalled consumer; in_valid during DONE is ignored.
    start16(16'd17, 16'd13);
    wait16(lat);
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'd100;
      b = 16'd10;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_res", res, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    release16();
    check("rel_idle", dut.state, IDLE);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("rel_res_kept", res, 32'd1);

    // Reset in the middle of REDUCE.
    start16(16'd1000, 16'd250);
    repeat (3) @(negedge clk);
    check("mid_reduce", dut.state, REDUCE);
    #1 reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_res", res, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_iters", iters, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abandoned", seen, 32'd0);
    start16(16'd12, 16'd8);
    wait16(lat);
    check("post_rst_res", res, 32'd4);
    release16();

`ifdef GCD_PARAM_ITERS_EN
    start16(16'd8, 16'd8);
    wait16(lat);
    check("res_8_8", res, 32'd8);
    check("iters_8_8", iters, reduce_cycles(8, 8));
    @(negedge clk);
    check("iters_hold", iters, reduce_cycles(8, 8));
    release16();
    start16(16'd3, 16'd5);
    check("iters_clear", iters, 32'd0);
    wait16(lat);
    release16();
`endif

    // Randomized WIDTH=16 operations.
    for (int unsigned i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) begin
        ra = ra << $urandom_range(0, 6);
        rb = rb << $urandom_range(0, 6);
      end
      if (i % 11 == 5) ra = '0;
      start16(ra, rb);
      wait16(lat);
      check("rnd_res", res, gcd_ref(ra, rb));
      check("rnd_lat", (lat <= BND) ? 1 : 0, 1);
`ifdef GCD_PARAM_ITERS_EN
      check("rnd_iters", iters, reduce_cycles(ra, rb));
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release16();
    end

    // WIDTH=8 sweep.
    for (int unsigned i = 0; i < 60; i++) begin
      op8(8'($urandom), 8'($urandom));
    end
    op8(8'hFF, 8'hFF);
    op8(8'h80, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gcd_param.md
GCD_PARAM -- requirements
Module: gcd_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (WIDTH >= 2).
REQ-002 SHALL have localparam CNT_W, default $clog2(4*WIDTH+3), iteration-counter width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 a  input  WIDTH  first operand, unsigned.
REQ-008 b  input  WIDTH  second operand, unsigned.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 res  output  WIDTH  gcd(a,b).
REQ-012 iters  output  CNT_W  cycles spent in REDUCE (only with GCD_PARAM_ITERS_EN).

Function
REQ-013 SHALL implement FSM IDLE, STRIP, REDUCE, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Accept on in_valid&&in_ready: x<=a, y<=b, k<=0; go STRIP.
REQ-015 STRIP, per cycle: if x==0 or y==0 go REDUCE; elif x and y both even, shift both right 1 and k++; else go REDUCE.
REQ-016 REDUCE, per cycle, first match wins: y==0 -> res<=x<<k, go DONE; x==0 -> res<=y<<k, go DONE; x even -> x>>=1; y even -> y>>=1; x>y -> x<=x-y; x<y -> y<=y-x; x==y -> y<=0.
REQ-017 Shift-left of result SHALL not overflow WIDTH (k never exceeds trailing zeros of the true gcd).
REQ-018 gcd(0,0)=0, gcd(0,b)=b, gcd(a,0)=a.
REQ-019 Latency accept-to-out_valid SHALL be <= 4*WIDTH+2 cycles for all operands.
REQ-020 DONE: res and out_valid held stable until out_ready; out_valid&&out_ready -> IDLE next cycle.
REQ-021 in_valid outside IDLE SHALL be ignored; operands sampled only at accept.
REQ-022 No simultaneous accept and release: new operands accepted at earliest the cycle after DONE exits.
REQ-023 All subtractions SHALL be WIDTH-bit unsigned, never performed with the smaller operand as minuend.

Reset
REQ-024 reset_n low SHALL asynchronously force state IDLE, x, y, k, res, iters to 0.
REQ-025 Outputs under reset: in_ready=1 after release (IDLE), out_valid=0, res=0, iters=0.
REQ-026 Reset mid-computation SHALL abandon the operation; no out_valid for it.

Configuration
REQ-027 Macro GCD_PARAM_ITERS_EN defined: iters counts REDUCE cycles of the current operation, cleared on accept, saturating at 2**CNT_W-1, held stable in DONE.
REQ-028 Macro undefined: iters port absent, counter not built; all other behaviour identical.

Structure
REQ-029 Package gcd_param_pkg SHALL hold the FSM state enum typedef and the iteration-bound function used for CNT_W.
REQ-030 Sub-module gcd_param_step SHALL be the combinational REDUCE datapath (x,y in; x_next,y_next,finish out); FSM and registers stay in gcd_param.

Verification
REQ-031 WIDTH=16, a=48, b=18 -> res=6, out_valid within 66 cycles, k reaches 1.
REQ-032 a=0,b=0 -> res=0; a=0,b=35 -> res=35; a=35,b=0 -> res=35.
REQ-033 a=b=16'hFFFF -> res=16'hFFFF; a=16'h8000,b=16'h4000 -> res=16'h4000, no overflow.
REQ-034 a=17,b=13 (coprime) -> res=1; out_ready low 5 cycles after out_valid -> res/out_valid stable, in_ready=0 throughout, IDLE one cycle after out_ready.
REQ-035 reset_n pulsed low mid-REDUCE of (1000,250) -> outputs 0 immediately, no out_valid; next op (12,8) -> res=4.
REQ-036 GCD_PARAM_ITERS_EN: (8,8) -> iters equals REDUCE cycle count from reference model; clears to 0 on next accept; WIDTH=8 randomized sweep vs software gcd.
